// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared FSM encoding and image-format constants for program_loader
package loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t HDR_HI  = 3'd0;
    localparam state_t HDR_LO  = 3'd1;
    localparam state_t LOAD    = 3'd2;
    localparam state_t CHECK   = 3'd3;
    localparam state_t RELEASE = 3'd4;
    localparam state_t DONE    = 3'd5;
    localparam state_t ERROR   = 3'd6;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == LOAD) || (s == CHECK);
    endfunction

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs big-endian bytes into 32-bit words, first byte lands in [31:24]
import loader_pkg::*;

module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    // The 4th byte completes the word combinationally so the caller can register it on the same edge.
    assign word_valid = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));
    assign word       = {shreg, byte_in};

    // Shift accepted bytes in and count position within the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            shreg    <= {shreg[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader writing a streamed image to imem, optional checksum via LOADER_CHECKSUM_EN
import loader_pkg::*;

module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              start_up,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t POST_LOAD = CHECK;
`else
    localparam state_t POST_LOAD = RELEASE;
`endif

    state_t          state;
    logic [7:0]      hdr_hi;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] word_cnt;
    logic            release_wait;
    logic            accept;
    logic            shift_en;
    logic            word_valid;
    logic [31:0]     packed_word;
    logic [15:0]     hdr_n;
    logic            oversize;
    logic            last_word;

    assign rx_ready  = rst_n && accepts_bytes(state);
    assign accept    = rx_valid && rx_ready;
    assign shift_en  = accept && (state == LOAD);
    assign hdr_n     = {hdr_hi, rx_data};
    assign oversize  = 32'(hdr_n) > (32'd1 << ADDR_W);
    assign last_word = (word_cnt + (ADDR_W+1)'(1)) == n_words;

    assign start_up = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERROR);
    assign busy     = (state == HDR_LO) || (state == LOAD) || (state == CHECK) || (state == RELEASE);

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of every payload byte, compared against the trailer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (shift_en) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    // Load sequencing plus the registered instruction-memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HDR_HI;
            hdr_hi       <= '0;
            n_words      <= '0;
            word_cnt     <= '0;
            release_wait <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (accept) begin
                        hdr_hi <= rx_data;
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        n_words <= hdr_n[ADDR_W:0];
                        if (hdr_n == 16'd0) begin
                            state <= POST_LOAD;
                        end else if (oversize) begin
                            state <= ERROR;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt[ADDR_W-1:0];
                        imem_wdata <= packed_word;
                        word_cnt   <= word_cnt + (ADDR_W+1)'(1);
                        if (last_word) begin
                            state <= POST_LOAD;
                        end
                    end
                end
                CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept) begin
                        state <= (rx_data == csum) ? RELEASE : ERROR;
                    end
`else
                    state <= ERROR;
`endif
                end
                RELEASE: begin
                    // Two cycles here: the last write lands, then the processor is let go.
                    if (release_wait) begin
                        state <= DONE;
                    end else begin
                        release_wait <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                ERROR:   state <= ERROR;
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

    localparam int ADDR_W = 10;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        longint            t;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              start_up;
    logic              busy;
    logic              done;
    logic              error;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    longint      wr_times[$];
    logic [31:0] img[$];
    logic [7:0]  csum;
    longint      acc_time;
    bit          expect_busy = 0;
    bit          busy_drop   = 0;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start_up   (start_up),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write must match the oldest expected write, including its timing.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_times.push_back($time);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e.addr));
                check("wr_data", 64'(imem_wdata), 64'(e.data));
                check("wr_time", 64'($time), 64'(e.t));
            end
        end
        if (expect_busy && !busy) busy_drop = 1'b1;
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        exp_q.delete();
        wr_times.delete();
        expect_busy = 0;
        busy_drop   = 0;
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst_start_up", 64'(start_up), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rx_ready", 64'(rx_ready), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        if (gaps) begin
            int n = $urandom_range(0, 3);
            repeat (n) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (!rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            n_checks++;
            $display("FAIL send_timeout: got rx_ready 0 expected 1");
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            acc_time = $time;
        end
    endtask

    task automatic send_header(input logic [15:0] n, input bit gaps);
        csum = 8'h00;
        send_byte(n[15:8], gaps);
        expect_busy = 1;
        send_byte(n[7:0], gaps);
    endtask

    // Reference model: word i goes to address i, big-endian, visible half a cycle after its 4th byte.
    task automatic send_payload(input bit gaps, input int max_bytes);
        int sent = 0;
        for (int i = 0; i < img.size(); i++) begin
            logic [31:0] w;
            w = img[i];
            for (int b = 0; b < 4; b++) begin
                logic [7:0] bv;
                if (max_bytes >= 0 && sent >= max_bytes) return;
                bv = w[31 - 8*b -: 8];
                send_byte(bv, gaps);
                csum = csum ^ bv;
                sent++;
                if (b == 3) exp_q.push_back('{addr: i[ADDR_W-1:0], data: w, t: acc_time + 5});
            end
        end
    endtask

    task automatic finish_image(input bit bad);
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad ? (csum ^ 8'h01) : csum, 1'b0);
`else
        if (bad) $display("note: checksum trailer not present in this build");
`endif
    endtask

    task automatic check_release(input string tag);
        @(negedge clk);
        rx_valid = 1'b0;
        check({tag, "_rel_busy"}, 64'(busy), 64'd1);
        check({tag, "_rel_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_rel_start_up0"}, 64'(start_up), 64'd1);
        expect_busy = 0;
        @(negedge clk);
        check({tag, "_rel_start_up1"}, 64'(start_up), 64'd1);
        check({tag, "_rel_done1"}, 64'(done), 64'd0);
        @(negedge clk);
        check({tag, "_start_up"}, 64'(start_up), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Two-word image, back-to-back.
        do_reset();
        img = '{32'h20080005, 32'h01095020};
        send_header(16'd2, 1'b0);
        send_payload(1'b0, -1);
        finish_image(1'b0);
        check_release("n2");
        check("n2_write_count", 64'(wr_times.size()), 64'd2);
        if (wr_times.size() == 2)
            check("n2_write_spacing", 64'(wr_times[1] - wr_times[0]), 64'd40);

        // Empty image.
        do_reset();
        img.delete();
        send_header(16'd0, 1'b0);
        finish_image(1'b0);
        check_release("n0");
        check("n0_no_writes", 64'(wr_times.size()), 64'd0);

        // Oversize count aborts the load.
        do_reset();
        send_header(16'((1 << ADDR_W) + 1), 1'b0);
        @(negedge clk);
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_rx_ready", 64'(rx_ready), 64'd0);
        check("ovf_start_up", 64'(start_up), 64'd1);
        check("ovf_busy", 64'(busy), 64'd0);
        rx_data = 8'hA5;
        repeat (8) @(negedge clk);
        rx_valid = 1'b0;
        check("ovf_error_hold", 64'(error), 64'd1);
        check("ovf_start_up_hold", 64'(start_up), 64'd1);
        check("ovf_done", 64'(done), 64'd0);
        check("ovf_no_writes", 64'(wr_times.size()), 64'd0);

        // Random rx_valid gaps on a three-word image.
        do_reset();
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        send_header(16'd3, 1'b1);
        send_payload(1'b1, -1);
        finish_image(1'b0);
        check_release("gap");
        check("gap_busy_held", 64'(busy_drop), 64'd0);
        check("gap_write_count", 64'(wr_times.size()), 64'd3);

        // Full-capacity image: last address is 2**ADDR_W-1 with no wrap.
        do_reset();
        img.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) img.push_back($urandom);
        send_header(16'(1 << ADDR_W), 1'b0);
        send_payload(1'b0, -1);
        finish_image(1'b0);
        check_release("full");
        check("full_write_count", 64'(wr_times.size()), 64'(1 << ADDR_W));

        // Reset mid-load, then a fresh one-word image.
        do_reset();
        img.delete();
        img.push_back($urandom);
        img.push_back($urandom);
        send_header(16'd2, 1'b0);
        send_payload(1'b0, 6);
        check("midrst_first_word_done", 64'(exp_q.size()), 64'd0);
        do_reset();
        img = '{32'hDEADBEEF};
        send_header(16'd1, 1'b0);
        send_payload(1'b0, -1);
        finish_image(1'b0);
        check_release("midrst");
        check("midrst_write_count", 64'(wr_times.size()), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        // Bad trailer keeps the processor held.
        do_reset();
        img.delete();
        for (int i = 0; i < 2; i++) img.push_back($urandom);
        send_header(16'd2, 1'b0);
        send_payload(1'b0, -1);
        finish_image(1'b1);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        check("csum_bad_error", 64'(error), 64'd1);
        check("csum_bad_start_up", 64'(start_up), 64'd1);
        check("csum_bad_done", 64'(done), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
